// File: rtl/loader_pkg.sv
// Shared definitions for the instruction-memory loader: FSM state encoding,
// frame header size and the value written to unused memory words.
package loader_pkg;

  typedef enum logic [2:0] {
    ST_LEN_LO = 3'd0,
    ST_LEN_HI = 3'd1,
    ST_DATA   = 3'd2,
    ST_CHECK  = 3'd3,
    ST_FILL   = 3'd4,
    ST_DONE   = 3'd5,
    ST_ERROR  = 3'd6
  } state_e;

  localparam int          LEN_BYTES = 2;
  localparam logic [31:0] FILL_WORD = 32'h0000_0000;

  // A frame length is acceptable when it names at least one word and fits in memory.
  function automatic logic len_ok(input logic [15:0] n, input logic [16:0] max_words);
    return (n != 16'd0) && ({1'b0, n} <= max_words);
  endfunction

endpackage

// File: rtl/word_packer.sv
// Packs a byte stream into 32-bit little-endian words; o_word_vld pulses in the
// same cycle as the fourth byte so the caller can register the write once.
module word_packer
  import loader_pkg::*;
(
  input  logic        i_clk,
  input  logic        i_clear,
  input  logic [7:0]  i_byte,
  input  logic        i_byte_en,
  output logic [31:0] o_word,
  output logic        o_word_vld
);

  logic [1:0]  r_lane;
  logic [23:0] r_shift;

  always_ff @(posedge i_clk) begin
    if (i_clear) begin
      r_lane  <= 2'd0;
      r_shift <= 24'd0;
    end else if (i_byte_en) begin
      case (r_lane)
        2'd0:    r_shift[7:0]   <= i_byte;
        2'd1:    r_shift[15:8]  <= i_byte;
        2'd2:    r_shift[23:16] <= i_byte;
        default: ;
      endcase
      r_lane <= r_lane + 2'd1;
    end
  end

  assign o_word_vld = i_byte_en && (r_lane == 2'd3);
  assign o_word     = {i_byte, r_shift};

endmodule

// File: rtl/imem_loader.sv
// Boot-time instruction-memory writer: length header, packed data words, zero fill,
// then CPU start. Optional trailing XOR check byte enabled by LOADER_CHECKSUM_EN.
module imem_loader
  import loader_pkg::*;
#(
  parameter int ADDR_W    = 8,
  parameter int MAX_WORDS = 256
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic [7:0]        byte_i,
  input  logic              byte_valid_i,
  output logic              byte_ready_o,
  output logic              imem_we_o,
  output logic [ADDR_W-1:0] imem_addr_o,
  output logic [31:0]       imem_data_o,
  output logic [ADDR_W:0]   word_count_o,
  output logic              cpu_start_o,
  output logic              done_o,
  output logic              error_o
);

  localparam logic [16:0] MAXW = 17'(MAX_WORDS);
  localparam logic [ADDR_W:0] ONE = {{ADDR_W{1'b0}}, 1'b1};

  state_e            r_state, w_next;
  logic [7:0]        r_len_lo;
  logic [15:0]       r_len;
  logic [ADDR_W:0]   r_idx;
  logic [ADDR_W:0]   r_wcount;
  logic              r_we;
  logic [ADDR_W-1:0] r_addr;
  logic [31:0]       r_data;

  logic        w_xfer;
  logic [15:0] w_hdr_len;
  logic        w_last_word;
  logic        w_full;
  logic        w_fill_last;
  state_e      w_after_data;
  logic [31:0] w_word;
  logic        w_word_vld;
  logic        w_pack_clear;

`ifdef LOADER_CHECKSUM_EN
  logic [7:0]  r_xor;
`endif

  always_comb begin
    byte_ready_o = 1'b0;
    case (r_state)
      ST_LEN_LO, ST_LEN_HI, ST_DATA, ST_CHECK: byte_ready_o = 1'b1;
      default:                                 byte_ready_o = 1'b0;
    endcase
  end

  assign w_xfer       = byte_valid_i && byte_ready_o;
  assign w_hdr_len    = {byte_i, r_len_lo};
  assign w_last_word  = ((17'(r_idx) + 17'd1) == {1'b0, r_len});
  assign w_full       = ({1'b0, r_len} == MAXW);
  assign w_fill_last  = (17'(r_idx) == (MAXW - 17'd1));
  assign w_after_data = w_full ? ST_DONE : ST_FILL;
  // The partial word is dropped whenever the stream is not in its data phase.
  assign w_pack_clear = rst_i || (r_state != ST_DATA);

  word_packer u_packer (
    .i_clk      (clk_i),
    .i_clear    (w_pack_clear),
    .i_byte     (byte_i),
    .i_byte_en  (w_xfer && (r_state == ST_DATA)),
    .o_word     (w_word),
    .o_word_vld (w_word_vld)
  );

  always_ff @(posedge clk_i) begin
    if (rst_i) r_state <= ST_LEN_LO;
    else       r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      ST_LEN_LO: if (w_xfer) w_next = ST_LEN_HI;
      ST_LEN_HI: if (w_xfer) w_next = len_ok(w_hdr_len, MAXW) ? ST_DATA : ST_ERROR;
      ST_DATA: begin
        if (w_word_vld && w_last_word) begin
`ifdef LOADER_CHECKSUM_EN
          w_next = ST_CHECK;
`else
          w_next = w_after_data;
`endif
        end
      end
      ST_CHECK: begin
`ifdef LOADER_CHECKSUM_EN
        if (w_xfer) w_next = (byte_i == r_xor) ? w_after_data : ST_ERROR;
`else
        w_next = ST_ERROR;
`endif
      end
      ST_FILL:  if (w_fill_last) w_next = ST_DONE;
      ST_DONE:  w_next = ST_DONE;
      ST_ERROR: w_next = ST_ERROR;
      default:  w_next = ST_ERROR;
    endcase
  end

  // Write port and counters; the write strobe is registered one cycle after the
  // fourth byte, and fill writes continue back-to-back from address N.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_len_lo <= 8'd0;
      r_len    <= 16'd0;
      r_idx    <= '0;
      r_wcount <= '0;
      r_we     <= 1'b0;
      r_addr   <= '0;
      r_data   <= 32'd0;
    end else begin
      r_we <= 1'b0;
      case (r_state)
        ST_LEN_LO: if (w_xfer) r_len_lo <= byte_i;
        ST_LEN_HI: if (w_xfer) r_len <= w_hdr_len;
        ST_DATA: begin
          if (w_word_vld) begin
            r_we     <= 1'b1;
            r_addr   <= r_idx[ADDR_W-1:0];
            r_data   <= w_word;
            r_idx    <= r_idx + ONE;
            r_wcount <= r_wcount + ONE;
          end
        end
        ST_FILL: begin
          r_we   <= 1'b1;
          r_addr <= r_idx[ADDR_W-1:0];
          r_data <= FILL_WORD;
          r_idx  <= r_idx + ONE;
        end
        default: ;
      endcase
    end
  end

`ifdef LOADER_CHECKSUM_EN
  always_ff @(posedge clk_i) begin
    if (rst_i)                              r_xor <= 8'd0;
    else if (w_xfer && r_state == ST_DATA)  r_xor <= r_xor ^ byte_i;
  end
`endif

  assign imem_we_o    = r_we;
  assign imem_addr_o  = r_addr;
  assign imem_data_o  = r_data;
  assign word_count_o = r_wcount;
  assign done_o       = (r_state == ST_DONE);
  assign cpu_start_o  = (r_state == ST_DONE);
  assign error_o      = (r_state == ST_ERROR);

endmodule

// File: tb/tb_imem_loader.sv
// Directed bench for imem_loader: framing, fill, length errors, stalls, reset
// mid-load and (with LOADER_CHECKSUM_EN) the trailing check byte.
module tb_imem_loader;

  localparam int ADDR_W    = 8;
  localparam int MAX_WORDS = 256;

  logic              clk = 1'b0;
  logic              rst_i = 1'b1;
  logic [7:0]        byte_i = 8'h00;
  logic              byte_valid_i = 1'b0;
  logic              byte_ready_o;
  logic              imem_we_o;
  logic [ADDR_W-1:0] imem_addr_o;
  logic [31:0]       imem_data_o;
  logic [ADDR_W:0]   word_count_o;
  logic              cpu_start_o;
  logic              done_o;
  logic              error_o;

  always #5 clk = ~clk;

  imem_loader #(.ADDR_W(ADDR_W), .MAX_WORDS(MAX_WORDS)) dut (
    .clk_i        (clk),
    .rst_i        (rst_i),
    .byte_i       (byte_i),
    .byte_valid_i (byte_valid_i),
    .byte_ready_o (byte_ready_o),
    .imem_we_o    (imem_we_o),
    .imem_addr_o  (imem_addr_o),
    .imem_data_o  (imem_data_o),
    .word_count_o (word_count_o),
    .cpu_start_o  (cpu_start_o),
    .done_o       (done_o),
    .error_o      (error_o)
  );

  int n_cmp = 0;
  int n_bad = 0;
  logic [31:0] mem     [0:MAX_WORDS-1];
  logic [31:0] exp_mem [0:MAX_WORDS-1];
  int wr_cnt = 0;
  int k;

  // Memory model fed by the write port, sampled mid-cycle.
  always @(negedge clk) begin
    if (imem_we_o) begin
      mem[imem_addr_o] = imem_data_o;
      wr_cnt = wr_cnt + 1;
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_cmp++;
    assert (obs === expv) else begin
      n_bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
    end
  endtask

  task automatic clear_model();
    for (int i = 0; i < MAX_WORDS; i++) begin
      mem[i]     = 32'hDEAD_BEEF;
      exp_mem[i] = 32'h0;
    end
    wr_cnt = 0;
  endtask

  function automatic int mem_mismatches();
    int m = 0;
    for (int i = 0; i < MAX_WORDS; i++) if (mem[i] !== exp_mem[i]) m++;
    return m;
  endfunction

  task automatic do_reset();
    @(negedge clk);
    rst_i = 1'b1;
    byte_valid_i = 1'b0;
    @(negedge clk);
    rst_i = 1'b0;
    clear_model();
  endtask

  task automatic send_byte(input logic [7:0] b, input int gap);
    int n;
    repeat (gap) @(negedge clk);
    @(negedge clk);
    byte_i = b;
    byte_valid_i = 1'b1;
    n = 0;
    while (!byte_ready_o && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (!byte_ready_o) check("ready_timeout", {31'd0, byte_ready_o}, 32'd1);
    @(posedge clk);
    #1 byte_valid_i = 1'b0;
  endtask

  task automatic send_word(input logic [31:0] w, input int maxgap);
    for (int i = 0; i < 4; i++) send_byte(w[8*i +: 8], $urandom_range(0, maxgap));
  endtask

  task automatic wait_end(output int cycles);
    cycles = 0;
    do begin
      @(negedge clk);
      cycles++;
    end while (!done_o && !error_o && cycles < 2000);
    if (!done_o && !error_o) check("end_timeout", 32'd0, 32'd1);
  endtask

  initial begin
    clear_model();
    // Reset state
    do_reset();
    check("rst_ready", {31'd0, byte_ready_o}, 32'd1);
    check("rst_we", {31'd0, imem_we_o}, 32'd0);
    check("rst_addr", {24'd0, imem_addr_o}, 32'd0);
    check("rst_data", imem_data_o, 32'd0);
    check("rst_wcount", {23'd0, word_count_o}, 32'd0);
    check("rst_flags", {29'd0, cpu_start_o, done_o, error_o}, 32'd0);

    // 1: N=3 with fill to 255
    send_byte(8'h03, 0); send_byte(8'h00, 0);
    send_byte(8'h13, 0); send_byte(8'h00, 0); send_byte(8'h00, 0); send_byte(8'h00, 0);
    send_byte(8'h22, 0); send_byte(8'h00, 0); send_byte(8'h00, 0); send_byte(8'h00, 0);
    send_byte(8'h08, 0); send_byte(8'h01, 0); send_byte(8'h00, 0); send_byte(8'h00, 0);
    exp_mem[0] = 32'h13; exp_mem[1] = 32'h22; exp_mem[2] = 32'h108;
    wait_end(k);
    check("t1_done_latency", k, 32'd254);
    check("t1_start", {30'd0, cpu_start_o, done_o}, 32'd3);
    @(negedge clk);
    check("t1_we_after", {31'd0, imem_we_o}, 32'd0);
    check("t1_ready", {31'd0, byte_ready_o}, 32'd0);
    check("t1_wcount", {23'd0, word_count_o}, 32'd3);
    check("t1_writes", wr_cnt, 32'd256);
    check("t1_mem", mem_mismatches(), 32'd0);
    check("t1_word2", mem[2], 32'h0000_0108);

    // 2: N=0
    do_reset();
    send_byte(8'h00, 0); send_byte(8'h00, 0);
    @(negedge clk);
    check("t2_error", {31'd0, error_o}, 32'd1);
    check("t2_ready", {31'd0, byte_ready_o}, 32'd0);
    repeat (5) @(negedge clk);
    check("t2_no_writes", wr_cnt, 32'd0);
    check("t2_flags", {29'd0, cpu_start_o, done_o, error_o}, 32'd1);

    // 3a: N=257
    do_reset();
    send_byte(8'h01, 0); send_byte(8'h01, 0);
    @(negedge clk);
    check("t3_err257", {31'd0, error_o}, 32'd1);
    repeat (3) @(negedge clk);
    check("t3_no_writes", wr_cnt, 32'd0);

    // 3b: N=256 full load, no fill
    do_reset();
    for (int i = 0; i < MAX_WORDS; i++) exp_mem[i] = {i[7:0], 8'h5A, ~i[7:0], i[7:0]};
    send_byte(8'h00, 0); send_byte(8'h01, 0);
    for (int i = 0; i < MAX_WORDS; i++) send_word(exp_mem[i], 0);
    wait_end(k);
    check("t3_done_latency", k, 32'd1);
    check("t3_last_addr", {24'd0, imem_addr_o}, 32'hFF);
    check("t3_last_we", {31'd0, imem_we_o}, 32'd1);
    @(negedge clk);
    check("t3_we_after", {31'd0, imem_we_o}, 32'd0);
    check("t3_wcount", {23'd0, word_count_o}, 32'd256);
    check("t3_writes", wr_cnt, 32'd256);
    check("t3_mem", mem_mismatches(), 32'd0);

    // 4: stalls inside N=2
    do_reset();
    exp_mem[0] = 32'h4433_2211; exp_mem[1] = 32'h8877_6655;
    send_byte(8'h02, 1); send_byte(8'h00, 2);
    send_word(32'h4433_2211, 2);
    send_word(32'h8877_6655, 2);
    wait_end(k);
    check("t4_done_latency", k, 32'd255);
    @(negedge clk);
    check("t4_wcount", {23'd0, word_count_o}, 32'd2);
    check("t4_mem", mem_mismatches(), 32'd0);
    check("t4_word1", mem[1], 32'h8877_6655);

    // 5: reset mid-load, then fresh frame
    do_reset();
    send_byte(8'h03, 0); send_byte(8'h00, 0);
    send_byte(8'h11, 0); send_byte(8'h22, 0); send_byte(8'h33, 0);
    send_byte(8'h44, 0); send_byte(8'h55, 0); send_byte(8'h66, 0);
    @(negedge clk);
    check("t5_pre_writes", wr_cnt, 32'd1);
    check("t5_pre_word0", mem[0], 32'h4433_2211);
    do_reset();
    check("t5_rst_wcount", {23'd0, word_count_o}, 32'd0);
    check("t5_rst_ready", {31'd0, byte_ready_o}, 32'd1);
    exp_mem[0] = 32'hDDCC_BBAA;
    send_byte(8'h01, 0); send_byte(8'h00, 0);
    send_byte(8'hAA, 0); send_byte(8'hBB, 0); send_byte(8'hCC, 0); send_byte(8'hDD, 0);
    wait_end(k);
    check("t5_done_latency", k, 32'd256);
    @(negedge clk);
    check("t5_word0", mem[0], 32'hDDCC_BBAA);
    check("t5_mem", mem_mismatches(), 32'd0);
    check("t5_wcount", {23'd0, word_count_o}, 32'd1);

`ifdef LOADER_CHECKSUM_EN
    // 6: check byte match and mismatch
    do_reset();
    exp_mem[0] = 32'h0804_0201;
    send_byte(8'h01, 0); send_byte(8'h00, 0);
    send_byte(8'h01, 0); send_byte(8'h02, 0); send_byte(8'h04, 0); send_byte(8'h08, 0);
    send_byte(8'h0F, 0);
    wait_end(k);
    check("t6_ok_done", {29'd0, cpu_start_o, done_o, error_o}, 32'd6);
    @(negedge clk);
    check("t6_ok_mem", mem_mismatches(), 32'd0);
    do_reset();
    send_byte(8'h01, 0); send_byte(8'h00, 0);
    send_byte(8'h01, 0); send_byte(8'h02, 0); send_byte(8'h04, 0); send_byte(8'h08, 0);
    send_byte(8'h0E, 0);
    wait_end(k);
    check("t6_bad_latency", k, 32'd1);
    check("t6_bad_flags", {29'd0, cpu_start_o, done_o, error_o}, 32'd1);
    repeat (3) @(negedge clk);
    check("t6_bad_word0", mem[0], 32'h0804_0201);
    check("t6_bad_writes", wr_cnt, 32'd1);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
